// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 8;
endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr wins.
module regfile_wr_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  int          j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j  = (int'(ptr) + k) % NREQ;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        idx     = jj;
        gnt[jj] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file write port with short locked bursts.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MAXLOCK = 4,
  parameter int R0_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic [AW-1:0]    wr_sel,
  output logic             wr_en,
  output logic [DW-1:0]    wr_data,
  output logic             locked
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [0:0]      state;
  logic [IW-1:0]   ptr, owner, win_idx, pick_idx;
  logic [3:0]      lcnt;
  logic [4:0]      lnext;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any, win_any;
  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   data_a [NREQ];
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*AW +: AW];
    assign data_a[g] = req_data[g*DW +: DW];
  end

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(NREQ-1)) ? '0 : i + 1'b1;
  endfunction

  regfile_wr_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // While locked only the owner can win; reset also masks the grant.
  always_comb begin
    gnt     = '0;
    win_idx = pick_idx;
    win_any = 1'b0;
    if (!stall && rst_n) begin
      if (state == ST_IDLE) begin
        gnt     = pick_gnt;
        win_any = pick_any;
      end else if (req[owner]) begin
        gnt[owner] = 1'b1;
        win_idx    = owner;
        win_any    = 1'b1;
      end
    end
  end

  assign win_addr = addr_a[win_idx];
  assign win_data = data_a[win_idx];
  assign lnext    = {1'b0, lcnt} + 5'd1;
  assign locked   = (state == ST_LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      owner   <= '0;
      lcnt    <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= win_any && !((R0_ZERO != 0) && (win_addr == '0));
      if (win_any) begin
        wr_sel  <= win_addr;
        wr_data <= win_data;
      end
      if (!stall) begin
        if (state == ST_IDLE) begin
          if (win_any) begin
            ptr <= inc(win_idx);
            if (req_lock[win_idx] && (MAXLOCK > 1)) begin
              state <= ST_LOCKED;
              owner <= win_idx;
              lcnt  <= 4'd1;
            end
          end
        end else if (req[owner] && req_lock[owner] && (lnext < 5'(MAXLOCK))) begin
          lcnt <= lnext[3:0];
        end else begin
          // Burst over: lock dropped, owner went quiet, or MAXLOCK reached.
          state <= ST_IDLE;
          ptr   <= inc(owner);
          lcnt  <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench: two arbiters (MAXLOCK 4 and 2) share stimulus, checked against a rule-level model.
module tb_regfile_wr_arbiter;
  typedef struct { bit lk; int own; int cnt; int ptr; } mst_t;
  typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;

  logic        clk, rst_n, stall;
  logic [3:0]  req, req_lock;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  gnt0, gnt1;
  logic [4:0]  wr_sel0, wr_sel1;
  logic        wr_en0, wr_en1, locked0, locked1;
  logic [7:0]  wr_data0, wr_data1;

  logic [3:0] rq, lk;
  logic [4:0] ad [4];
  logic [7:0] dd [4];
  mst_t ms [2];
  wr_t  q0 [$];
  wr_t  q1 [$];
  wr_t  me;
  int   total, bad, w0;

  regfile_wr_arbiter #(.NREQ(4), .AW(5), .DW(8), .MAXLOCK(4), .R0_ZERO(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req(req), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt0), .wr_sel(wr_sel0),
    .wr_en(wr_en0), .wr_data(wr_data0), .locked(locked0));

  regfile_wr_arbiter #(.NREQ(4), .AW(5), .DW(8), .MAXLOCK(2), .R0_ZERO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req(req), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt1), .wr_sel(wr_sel1),
    .wr_en(wr_en1), .wr_data(wr_data1), .locked(locked1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules: rotate-priority scan in IDLE, owner-only while locked.
  task automatic model_step(input int k, output int w);
    mst_t s;
    int   ml, i;
    s  = ms[k];
    ml = (k == 0) ? 4 : 2;
    w  = -1;
    if (!stall) begin
      if (!s.lk) begin
        for (int n = 0; n < 4; n++) begin
          i = (s.ptr + n) % 4;
          if (w < 0 && req[i]) w = i;
        end
        if (w >= 0) begin
          s.ptr = (w + 1) % 4;
          if (req_lock[w] && ml > 1) begin s.lk = 1; s.own = w; s.cnt = 1; end
        end
      end else if (req[s.own]) begin
        w = s.own;
        s.cnt++;
        if (!req_lock[w] || s.cnt >= ml) begin s.lk = 0; s.ptr = (w + 1) % 4; end
      end else begin
        s.lk  = 0;
        s.ptr = (s.own + 1) % 4;
      end
    end
    ms[k] = s;
  endtask

  task automatic cyc(input bit st);
    int  w;
    wr_t e;
    @(posedge clk); #1;
    req = rq; req_lock = lk; stall = st;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*5 +: 5] = ad[i];
      req_data[i*8 +: 8] = dd[i];
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("locked%0d", k), (k == 0) ? locked0 : locked1, ms[k].lk);
      model_step(k, w);
      chk($sformatf("gnt%0d", k), (k == 0) ? gnt0 : gnt1, (w < 0) ? 0 : (1 << w));
      if (w >= 0 && ad[w] != 0) begin
        e.a = ad[w]; e.d = dd[w];
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (k == 0) w0 = w;
    end
  endtask

  task automatic reroll(input int i);
    rq[i] = ($urandom_range(0, 3) != 0);
    lk[i] = ($urandom_range(0, 2) == 0);
    ad[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    dd[i] = 8'($urandom);
  endtask

  // Monitor: every registered write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL wr0_unexpected actual_sel=%0d required=no write", wr_sel0);
        end else begin
          me = q0.pop_front();
          chk("wr_sel0", wr_sel0, me.a);
          chk("wr_data0", wr_data0, me.d);
        end
      end
      if (wr_en1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL wr1_unexpected actual_sel=%0d required=no write", wr_sel1);
        end else begin
          me = q1.pop_front();
          chk("wr_sel1", wr_sel1, me.a);
          chk("wr_data1", wr_data1, me.d);
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; w0 = -1;
    for (int k = 0; k < 2; k++) ms[k] = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin ad[i] = 5'(10 + i); dd[i] = 8'(8'h40 + i); end
    rst_n = 1'b0; stall = 1'b0; req = 4'b1111; req_lock = 4'b0;
    req_addr = '0; req_data = '0; rq = 4'b0; lk = 4'b0;
    #12;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_wr_en0", wr_en0, 0);
    chk("rst_wr_sel0", wr_sel0, 0);
    chk("rst_wr_data0", wr_data0, 0);
    chk("rst_locked0", locked0, 0);
    req = 4'b0;
    rst_n = 1'b1;

    // Fairness: all four requesting, no lock.
    rq = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      cyc(0);
      chk("fair_seq", gnt0, 1 << (c % 4));
    end

    // Burst: move ptr to 2, then source 2 locks for addrs 5,6,7 with source 0 waiting.
    rq = 4'b0010; cyc(0);
    rq = 4'b0101; lk = 4'b0100; ad[0] = 5'd9; ad[2] = 5'd5; dd[2] = 8'h15; cyc(0);
    chk("burst_first", gnt0, 4'b0100);
    ad[2] = 5'd6; dd[2] = 8'h16; cyc(0);
    chk("burst_cut_maxlock2", gnt1, 4'b0100);
    ad[2] = 5'd7; dd[2] = 8'h17; lk = 4'b0000; cyc(0);
    chk("burst_third", gnt0, 4'b0100);
    chk("maxlock2_next_src0", gnt1, 4'b0001);
    rq = 4'b0001; cyc(0);
    chk("after_burst_src0", gnt0, 4'b0001);

    // Stall mid-stream.
    rq = 4'b1111; cyc(0); cyc(0);
    cyc(1); cyc(1); cyc(1);
    cyc(0); cyc(0);

    // Writes to r0 are granted but dropped.
    rq = 4'b0010; ad[1] = 5'd0; dd[1] = 8'hA5; cyc(0);
    chk("r0_gnt", gnt0, 4'b0010);
    ad[1] = 5'd3; dd[1] = 8'h5A; cyc(0);
    rq = 4'b0; cyc(0);

    // Randomized traffic honouring the hold-until-granted handshake.
    for (int i = 0; i < 4; i++) reroll(i);
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 9) == 0);
      if (w0 >= 0) reroll(w0);
      for (int i = 0; i < 4; i++) if (!rq[i] && $urandom_range(0, 1) == 1) reroll(i);
    end

    // Asynchronous reset in the middle of a locked burst.
    rq = 4'b0; lk = 4'b0; cyc(0); cyc(0);
    rq = 4'b0001; lk = 4'b0001; ad[0] = 5'd4; dd[0] = 8'h3C; cyc(0);
    ad[0] = 5'd8; dd[0] = 8'h3D; cyc(0);
    #1;
    chk("pre_arst_locked0", locked0, 1);
    chk("pre_arst_wr_en0", wr_en0, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_locked0", locked0, 0);
    chk("arst_wr_en0", wr_en0, 0);
    chk("arst_locked1", locked1, 0);
    chk("arst_wr_en1", wr_en1, 0);
    chk("arst_gnt0", gnt0, 0);
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) ms[k] = '{0, 0, 0, 0};
    rq = 4'b0; lk = 4'b0; req = 4'b0; req_lock = 4'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc(0); cyc(0);
    rq = 4'b0110; ad[1] = 5'd21; ad[2] = 5'd22; cyc(0);
    chk("post_arst_ptr0", gnt0, 4'b0010);
    rq = 4'b0100; cyc(0);
    rq = 4'b0; cyc(0); cyc(0); cyc(0);
    @(negedge clk); #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
